// File: rtl/ex_mem_reg_pkg.sv
// Shared core defines: bus widths, enables, opcodes, stall indices, EX/MEM payload.
package ex_mem_reg_pkg;

    localparam int unsigned RegBus       = 32;
    localparam int unsigned RegAddrBus   = 5;
    localparam int unsigned AluOpBus     = 8;
    localparam int unsigned DoubleRegBus = 64;
    localparam int unsigned CntBus       = 2;

    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;

    localparam logic [AluOpBus-1:0] EXE_NOP_OP = 8'h00;

    localparam int unsigned STALL_PC  = 0;
    localparam int unsigned STALL_IF  = 1;
    localparam int unsigned STALL_ID  = 2;
    localparam int unsigned STALL_EX  = 3;
    localparam int unsigned STALL_MEM = 4;
    localparam int unsigned STALL_WB  = 5;

    typedef struct packed {
        logic [RegAddrBus-1:0] wd;
        logic                  wreg;
        logic [RegBus-1:0]     wdata;
        logic                  whilo;
        logic [RegBus-1:0]     hi;
        logic [RegBus-1:0]     lo;
        logic [AluOpBus-1:0]   aluop;
        logic [RegBus-1:0]     mem_addr;
        logic [RegBus-1:0]     reg2;
    } ex_mem_t;

    // All-zero payload: no GPR/HI/LO write, NOP opcode.
    localparam ex_mem_t EX_MEM_BUBBLE = '{
        wd: '0, wreg: WriteDisable, wdata: '0, whilo: WriteDisable,
        hi: '0, lo: '0, aluop: EXE_NOP_OP, mem_addr: '0, reg2: '0
    };

endpackage

// File: rtl/ex_mem_reg.sv
// EX->MEM pipeline register with stall/flush/bubble handling and MADD/MSUB carry state.
// Define MADD_EN to implement the hilo/cnt loop-back storage; otherwise hilo_o/cnt_o are 0.
module ex_mem_reg
    import ex_mem_reg_pkg::*;
#(
    parameter int unsigned STALL_W = 6,
    parameter int unsigned EX_IDX  = 3,
    parameter int unsigned MEM_IDX = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_W-1:0]      stall,
    input  logic                    flush,
    input  logic [RegAddrBus-1:0]   ex_wd,
    input  logic                    ex_wreg,
    input  logic [RegBus-1:0]       ex_wdata,
    input  logic                    ex_whilo,
    input  logic [RegBus-1:0]       ex_hi,
    input  logic [RegBus-1:0]       ex_lo,
    input  logic [AluOpBus-1:0]     ex_aluop,
    input  logic [RegBus-1:0]       ex_mem_addr,
    input  logic [RegBus-1:0]       ex_reg2,
    input  logic [DoubleRegBus-1:0] hilo_i,
    input  logic [CntBus-1:0]       cnt_i,
    output logic [RegAddrBus-1:0]   mem_wd,
    output logic                    mem_wreg,
    output logic [RegBus-1:0]       mem_wdata,
    output logic                    mem_whilo,
    output logic [RegBus-1:0]       mem_hi,
    output logic [RegBus-1:0]       mem_lo,
    output logic [AluOpBus-1:0]     mem_aluop,
    output logic [RegBus-1:0]       mem_mem_addr,
    output logic [RegBus-1:0]       mem_reg2,
    output logic [DoubleRegBus-1:0] hilo_o,
    output logic [CntBus-1:0]       cnt_o
);

    ex_mem_t ex_bus;
    ex_mem_t mem_q;
    logic    ex_stall;
    logic    mem_stall;
    logic    unused_stall;

    assign ex_stall     = stall[EX_IDX];
    assign mem_stall    = stall[MEM_IDX];
    assign unused_stall = ^stall;

    assign ex_bus = '{
        wd: ex_wd, wreg: ex_wreg, wdata: ex_wdata, whilo: ex_whilo,
        hi: ex_hi, lo: ex_lo, aluop: ex_aluop, mem_addr: ex_mem_addr, reg2: ex_reg2
    };

    // Payload register: rst > flush > bubble > capture > hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= EX_MEM_BUBBLE;
        end else if (flush) begin
            mem_q <= EX_MEM_BUBBLE;
        end else if (ex_stall && !mem_stall) begin
            mem_q <= EX_MEM_BUBBLE;
        end else if (!ex_stall) begin
            mem_q <= ex_bus;
        end
    end

    assign mem_wd       = mem_q.wd;
    assign mem_wreg     = mem_q.wreg;
    assign mem_wdata    = mem_q.wdata;
    assign mem_whilo    = mem_q.whilo;
    assign mem_hi       = mem_q.hi;
    assign mem_lo       = mem_q.lo;
    assign mem_aluop    = mem_q.aluop;
    assign mem_mem_addr = mem_q.mem_addr;
    assign mem_reg2     = mem_q.reg2;

`ifdef MADD_EN
    logic [DoubleRegBus-1:0] hilo_q;
    logic [CntBus-1:0]       cnt_q;

    // Partial product survives only while EX is stalled by its own MADD/MSUB sequence.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            hilo_q <= '0;
            cnt_q  <= '0;
        end else if (ex_stall && !mem_stall) begin
            hilo_q <= hilo_i;
            cnt_q  <= cnt_i;
        end else if (!ex_stall) begin
            hilo_q <= '0;
            cnt_q  <= '0;
        end
    end

    assign hilo_o = hilo_q;
    assign cnt_o  = cnt_q;
`else
    logic unused_madd;

    assign unused_madd = ^{hilo_i, cnt_i};
    assign hilo_o      = '0;
    assign cnt_o       = '0;
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed self-checking bench for ex_mem_reg; expectations follow MADD_EN when defined.
module tb_ex_mem_reg;
    import ex_mem_reg_pkg::*;

    logic                    clk;
    logic                    rst;
    logic [5:0]              stall;
    logic                    flush;
    logic [RegAddrBus-1:0]   ex_wd;
    logic                    ex_wreg;
    logic [RegBus-1:0]       ex_wdata;
    logic                    ex_whilo;
    logic [RegBus-1:0]       ex_hi;
    logic [RegBus-1:0]       ex_lo;
    logic [AluOpBus-1:0]     ex_aluop;
    logic [RegBus-1:0]       ex_mem_addr;
    logic [RegBus-1:0]       ex_reg2;
    logic [DoubleRegBus-1:0] hilo_i;
    logic [CntBus-1:0]       cnt_i;
    logic [RegAddrBus-1:0]   mem_wd;
    logic                    mem_wreg;
    logic [RegBus-1:0]       mem_wdata;
    logic                    mem_whilo;
    logic [RegBus-1:0]       mem_hi;
    logic [RegBus-1:0]       mem_lo;
    logic [AluOpBus-1:0]     mem_aluop;
    logic [RegBus-1:0]       mem_mem_addr;
    logic [RegBus-1:0]       mem_reg2;
    logic [DoubleRegBus-1:0] hilo_o;
    logic [CntBus-1:0]       cnt_o;

    int checks = 0;
    int errors = 0;

`ifdef MADD_EN
    localparam logic madd = 1'b1;
`else
    localparam logic madd = 1'b0;
`endif

    ex_mem_reg #(.STALL_W(6), .EX_IDX(3), .MEM_IDX(4)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_whilo(ex_whilo),
        .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr),
        .ex_reg2(ex_reg2), .hilo_i(hilo_i), .cnt_i(cnt_i),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_whilo(mem_whilo),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr),
        .mem_reg2(mem_reg2), .hilo_o(hilo_o), .cnt_o(cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_mem_zero(input string tag);
        chk({tag, ".wd"},    64'(mem_wd), 64'h0);
        chk({tag, ".wreg"},  64'(mem_wreg), 64'h0);
        chk({tag, ".wdata"}, 64'(mem_wdata), 64'h0);
        chk({tag, ".whilo"}, 64'(mem_whilo), 64'h0);
        chk({tag, ".hi"},    64'(mem_hi), 64'h0);
        chk({tag, ".lo"},    64'(mem_lo), 64'h0);
        chk({tag, ".aluop"}, 64'(mem_aluop), 64'h0);
        chk({tag, ".addr"},  64'(mem_mem_addr), 64'h0);
        chk({tag, ".reg2"},  64'(mem_reg2), 64'h0);
    endtask

    task automatic drive_ex(input logic [4:0] wd, input logic [31:0] wdata, input logic [7:0] op);
        ex_wd = wd; ex_wreg = 1'b1; ex_wdata = wdata; ex_whilo = 1'b1;
        ex_hi = wdata ^ 32'hA5A5_0000; ex_lo = wdata ^ 32'h0000_5A5A;
        ex_aluop = op; ex_mem_addr = wdata + 32'h1000; ex_reg2 = ~wdata;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; stall = 6'b0;
        drive_ex(5'd31, 32'hDEAD_BEEF, 8'h23);
        hilo_i = 64'h1234_5678_9ABC_DEF0; cnt_i = 2'd3;
        step();
        chk_mem_zero("reset");
        chk("reset.hilo", hilo_o, 64'h0);
        chk("reset.cnt", 64'(cnt_o), 64'h0);

        // Normal capture
        rst = 1'b0;
        drive_ex(5'd8, 32'h0000_0001, 8'h2B);
        step();
        chk("cap.wd", 64'(mem_wd), 64'd8);
        chk("cap.wreg", 64'(mem_wreg), 64'd1);
        chk("cap.wdata", 64'(mem_wdata), 64'h1);
        chk("cap.whilo", 64'(mem_whilo), 64'd1);
        chk("cap.hi", 64'(mem_hi), 64'hA5A5_0001);
        chk("cap.lo", 64'(mem_lo), 64'h0000_5A5B);
        chk("cap.aluop", 64'(mem_aluop), 64'h2B);
        chk("cap.addr", 64'(mem_mem_addr), 64'h1001);
        chk("cap.reg2", 64'(mem_reg2), 64'hFFFF_FFFE);
        chk("cap.hilo", hilo_o, 64'h0);
        chk("cap.cnt", 64'(cnt_o), 64'h0);

        // Bubble while EX stalls on MADD
        stall = 6'b001111;
        hilo_i = 64'h0000_0001_0000_0002; cnt_i = 2'd1;
        step();
        chk_mem_zero("bubble");
        chk("bubble.hilo", hilo_o, madd ? 64'h0000_0001_0000_0002 : 64'h0);
        chk("bubble.cnt", 64'(cnt_o), madd ? 64'd1 : 64'd0);

        // Both stalled: hold bubble and partial product
        stall = 6'b011111;
        hilo_i = 64'hCAFE_0000_0000_BABE; cnt_i = 2'd2;
        step();
        chk_mem_zero("holdb");
        chk("holdb.hilo", hilo_o, madd ? 64'h0000_0001_0000_0002 : 64'h0);
        chk("holdb.cnt", 64'(cnt_o), madd ? 64'd1 : 64'd0);

        // Resume capture immediately, loop state cleared
        stall = 6'b0;
        drive_ex(5'd3, 32'h0000_0005, 8'h24);
        step();
        chk("resume.wd", 64'(mem_wd), 64'd3);
        chk("resume.wdata", 64'(mem_wdata), 64'h5);
        chk("resume.hilo", hilo_o, 64'h0);
        chk("resume.cnt", 64'(cnt_o), 64'h0);

        // Hold a captured value for 3 cycles
        stall = 6'b011111;
        drive_ex(5'd9, 32'h0000_0009, 8'h20);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold.wdata", 64'(mem_wdata), 64'h5);
            chk("hold.wd", 64'(mem_wd), 64'd3);
            chk("hold.wreg", 64'(mem_wreg), 64'd1);
        end

        // Release the hold: next edge captures the waiting instruction
        stall = 6'b0;
        step();
        chk("release.wdata", 64'(mem_wdata), 64'h9);
        chk("release.wd", 64'(mem_wd), 64'd9);
        chk("release.aluop", 64'(mem_aluop), 64'h20);

        // Build up partial product, then flush over stall
        stall = 6'b001111;
        hilo_i = 64'h0000_00AA_0000_00BB; cnt_i = 2'd1;
        step();
        flush = 1'b1;
        hilo_i = 64'h1111_2222_3333_4444; cnt_i = 2'd2;
        step();
        chk_mem_zero("flush_st");
        chk("flush_st.hilo", hilo_o, 64'h0);
        chk("flush_st.cnt", 64'(cnt_o), 64'h0);

        // Flush with no stall kills the transfer
        stall = 6'b0;
        drive_ex(5'd12, 32'h0000_00C0, 8'h2B);
        step();
        chk_mem_zero("flush_ns");

        // rst overrides flush and a pending capture
        flush = 1'b0;
        step();
        chk("precap.wdata", 64'(mem_wdata), 64'hC0);
        rst = 1'b1; flush = 1'b1;
        step();
        chk_mem_zero("rst_fl");
        rst = 1'b0; flush = 1'b0;

        // All-ones partial product under a bubble
        stall = 6'b001111;
        hilo_i = 64'hFFFF_FFFF_FFFF_FFFF; cnt_i = 2'd3;
        step();
        chk("ones.hilo", hilo_o, madd ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0);
        chk("ones.cnt", 64'(cnt_o), madd ? 64'd3 : 64'd0);
        chk("ones.wreg", 64'(mem_wreg), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_mem_reg.md
# ex_mem_reg

Pipeline register between the EX stage and the MEM stage of the five-stage MIPS core. It captures the EX-stage result (ALU/compare/shift/move result, destination register, HI/LO write) together with memory-access operands. It applies the global stall vector and flush, and inserts a bubble into MEM when EX stalls but MEM does not. It also holds the intermediate 64-bit product and cycle counter that EX needs across the two-cycle MADD/MSUB sequence.

## Interface
Parameters:
- STALL_W, 6, width of the global stall vector (PC, IF, ID, EX, MEM, WB).
- EX_IDX, 3, stall-vector bit for EX.
- MEM_IDX, 4, stall-vector bit for MEM.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset rst, synchronous, active-high.
- stall  in  STALL_W  global stall vector from the stall controller.
- flush  in  1  exception flush; kills the EX→MEM transfer.
- ex_wd  in  5  destination GPR address.
- ex_wreg  in  1  GPR write enable.
- ex_wdata  in  32  EX result (already muxed from compare/logic/shift/arith units).
- ex_whilo  in  1  HI/LO write enable.
- ex_hi, ex_lo  in  32 each  HI/LO write values.
- ex_aluop  in  8  operation code, forwarded for load/store decoding.
- ex_mem_addr  in  32  effective address.
- ex_reg2  in  32  store data.
- hilo_i  in  64  EX-side MADD/MSUB partial product.
- cnt_i  in  2  EX-side MADD/MSUB cycle counter.
- mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, mem_aluop, mem_mem_addr, mem_reg2  out  same widths  registered copies for MEM.
- hilo_o  out  64  registered partial product returned to EX.
- cnt_o  out  2  registered cycle counter returned to EX.

## Operation
Per-edge update, priority highest first:
- rst=1: every output ← 0.
- flush=1: every mem_* output ← 0 (bubble: wreg=0, whilo=0, aluop=NOP 8'h00). hilo_o ← 0, cnt_o ← 0.
- stall[EX_IDX]=1 and stall[MEM_IDX]=0: mem_* ← 0 (bubble into MEM). hilo_o ← hilo_i, cnt_o ← cnt_i, which preserves MADD/MSUB progress.
- stall[EX_IDX]=0: mem_* ← ex_*. hilo_o ← 0, cnt_o ← 0.
- Otherwise (EX and MEM both stalled): hold all outputs.

Further rules:
- No arithmetic in this block. Values are copied bit-exact with no sign or zero extension.
- A bubble never asserts mem_wreg or mem_whilo. Downstream forwarding relies on this.
- Flush during a MADD/MSUB sequence discards the partial product; the instruction restarts after the exception.

## Timing
- Latency 1 cycle from ex_* to mem_*.
- hilo_o/cnt_o are visible to EX in the cycle after capture. This completes the 2-cycle MADD/MSUB loop: cycle 1 EX requests a stall with cnt_i=1; cycle 2 EX sees cnt_o=1 and accumulates.
- Reset, flush and stall are sampled at the same edge. rst overrides flush, and flush overrides stall.
- Deasserting stall resumes capture on the very next edge, with no extra bubble.

## Configuration
- MADD_EN defined: hilo_i/cnt_i/hilo_o/cnt_o are implemented as described.
- MADD_EN undefined: the ports remain, hilo_o and cnt_o are tied to 0, and no storage is inferred. EX must then not issue MADD/MSUB.

## Structure
- The shared defines package holds:
  - bus widths: RegBus 32, RegAddrBus 5, AluOpBus 8, DoubleRegBus 64;
  - WriteEnable/WriteDisable;
  - EXE_NOP_OP;
  - stall index constants.
- Single flat module; no sub-module is warranted.

## Test plan
- Reset: rst=1 with ex_wdata=32'hDEADBEEF, ex_wreg=1 → all outputs 0 after the edge.
- Normal capture: stall=0, ex_wd=5'd8, ex_wdata=32'h1, ex_wreg=1 → next cycle mem_wd=8, mem_wdata=1, mem_wreg=1.
- Bubble: stall=6'b001111 → mem_wreg=0 and mem_wdata=0; hilo_o=hilo_i=64'h0000_0001_0000_0002 and cnt_o=cnt_i=1.
- Hold: stall=6'b011111 after a capture of mem_wdata=32'h5 → mem_wdata stays 5 for 3 cycles.
- Flush over stall: flush=1 and stall=6'b001111, with hilo_i nonzero → hilo_o=0, cnt_o=0, mem_* all 0.
- MADD_EN undefined: drive hilo_i=64'hFFFF_FFFF_FFFF_FFFF under a bubble → hilo_o stays 0.
